// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants for the Mem-stage data RAM: store size codes, region base,
// controller state encoding and the size-code decoder.
package data_ram_ctrl_pkg;

  localparam logic [3:0] SIZE_SD = 4'b1000;
  localparam logic [3:0] SIZE_SW = 4'b0100;
  localparam logic [3:0] SIZE_SH = 4'b0010;
  localparam logic [3:0] SIZE_SB = 4'b0001;

  localparam logic [63:0] DATA_RAM_BASE = 64'h8000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic       legal;
    logic [3:0] nbytes;
    logic [7:0] be_base;
  } store_size_t;

  // Unknown codes decode to an illegal, zero-width store.
  function automatic store_size_t decode_size(input logic [3:0] wmask);
    store_size_t sz;
    sz = '0;
    case (wmask)
      SIZE_SD: sz = '{legal: 1'b1, nbytes: 4'd8, be_base: 8'hFF};
      SIZE_SW: sz = '{legal: 1'b1, nbytes: 4'd4, be_base: 8'h0F};
      SIZE_SH: sz = '{legal: 1'b1, nbytes: 4'd2, be_base: 8'h03};
      SIZE_SB: sz = '{legal: 1'b1, nbytes: 4'd1, be_base: 8'h01};
      default: sz = '0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/data_ram_ctrl_array.sv
// DEPTH_WORDS x 64 storage with per-byte write enables, one synchronous
// write port and one combinational read port. Contents are never reset.
module data_ram_array
  #(parameter int DEPTH_WORDS = 4096)
  (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] widx,
    input  logic [7:0]                     wbe,
    input  logic [63:0]                    wdata,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ridx,
    output logic [63:0]                    rdata
  );

  logic [63:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wbe[b]) begin
          mem_q[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/data_ram_ctrl.sv
// Mem-stage load/store responder: byte-lane stores into the on-chip data RAM
// and fixed-latency, right-aligned loads with range/alignment fault reporting.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
  #(
    parameter int          DEPTH_WORDS  = 4096,
    parameter int          READ_LATENCY = 2,
    parameter logic [63:0] BASE_ADDR    = DATA_RAM_BASE
  )
  (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] Raddr,
    input  logic [63:0] Waddr,
    input  logic [63:0] WData,
    input  logic [3:0]  Wmask,
    output logic [63:0] RamRData,
    output logic        RamReadReady,
    output logic        RamBusy,
    output logic        AccessFault
  );

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
    logic [2:0]       off;
  } addr_dec_t;

  // Full 64-bit difference: addresses far above the region must not wrap
  // back into it through a truncated index.
  function automatic addr_dec_t decode_addr(input logic [63:0] addr);
    addr_dec_t   dec;
    logic [63:0] diff;
    diff    = addr - BASE_ADDR;
    dec.ok  = (addr >= BASE_ADDR) && (diff[63:IDX_W+3] == '0);
    dec.idx = diff[IDX_W+2:3];
    dec.off = diff[2:0];
    return dec;
  endfunction

  // Store path
  addr_dec_t   w_dec;
  store_size_t w_sz;
  logic        w_req;
  logic        w_misalign;
  logic        w_we;
  logic [7:0]  w_be;
  logic [63:0] w_data;
  logic        wr_fault_d, wr_fault_q;

  always_comb begin
    w_dec      = decode_addr(Waddr);
    w_sz       = decode_size(Wmask);
    w_req      = (Waddr != '0) && w_sz.legal;
    w_misalign = |({1'b0, w_dec.off} & (w_sz.nbytes - 4'd1));
    w_we       = w_req && w_dec.ok && !w_misalign && Rst;
    wr_fault_d = w_req && !(w_dec.ok && !w_misalign);
    w_be       = w_sz.be_base << w_dec.off;
    w_data     = WData << {w_dec.off, 3'b000};
  end

  // Load FSM
  addr_dec_t        r_dec;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [IDX_W-1:0] rd_idx_d, rd_idx_q;
  logic [2:0]       rd_off_d, rd_off_q;
  logic             rd_fault_d, rd_fault_q;
  logic [63:0]      rdata_hold_d, rdata_hold_q;
  logic [63:0]      arr_rdata;
  logic [63:0]      resp_data;

  always_comb begin
    r_dec        = decode_addr(Raddr);
    resp_data    = rd_fault_q ? '0 : (arr_rdata >> {rd_off_q, 3'b000});
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_idx_d     = rd_idx_q;
    rd_off_d     = rd_off_q;
    rd_fault_d   = rd_fault_q;
    rdata_hold_d = rdata_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (Raddr != '0) begin
          rd_idx_d   = r_dec.idx;
          rd_off_d   = r_dec.off;
          rd_fault_d = !r_dec.ok;
          cnt_d      = CNT_LOAD;
          state_d    = (READ_LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        rdata_hold_d = resp_data;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rd_fault_q   <= 1'b0;
      wr_fault_q   <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_fault_q   <= rd_fault_d;
      wr_fault_q   <= wr_fault_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  // Latched read address carries no control meaning, so it is not reset.
  always_ff @(posedge Clk) begin
    rd_idx_q <= rd_idx_d;
    rd_off_q <= rd_off_d;
  end

  // Reading in RESP (not at accept) makes stores issued during WAIT visible.
  data_ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (Clk),
    .we    (w_we),
    .widx  (w_dec.idx),
    .wbe   (w_be),
    .wdata (w_data),
    .ridx  (rd_idx_q),
    .rdata (arr_rdata)
  );

  assign RamReadReady = (state_q == ST_RESP);
  assign RamBusy      = (state_q != ST_IDLE);
  assign RamRData     = (state_q == ST_RESP) ? resp_data : rdata_hold_q;
  assign AccessFault  = wr_fault_q || ((state_q == ST_RESP) && rd_fault_q);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: latency-2 main instance plus latency-1
// and latency-4 instances sharing the same stimulus.
module tb_data_ram_ctrl;

  localparam logic [3:0]  SD   = 4'b1000;
  localparam logic [3:0]  SW   = 4'b0100;
  localparam logic [3:0]  SH   = 4'b0010;
  localparam logic [3:0]  SB   = 4'b0001;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [63:0] Raddr = '0, Waddr = '0, WData = '0;
  logic [3:0]  Wmask = '0;

  logic [63:0] rd2, rd1, rd4;
  logic        rdy2, rdy1, rdy4;
  logic        busy2, busy1, busy4;
  logic        flt2, flt1, flt4;

  data_ram_ctrl #(.READ_LATENCY(2)) u_l2 (
    .Clk(Clk), .Rst(Rst), .Raddr(Raddr), .Waddr(Waddr), .WData(WData), .Wmask(Wmask),
    .RamRData(rd2), .RamReadReady(rdy2), .RamBusy(busy2), .AccessFault(flt2));
  data_ram_ctrl #(.READ_LATENCY(1)) u_l1 (
    .Clk(Clk), .Rst(Rst), .Raddr(Raddr), .Waddr(Waddr), .WData(WData), .Wmask(Wmask),
    .RamRData(rd1), .RamReadReady(rdy1), .RamBusy(busy1), .AccessFault(flt1));
  data_ram_ctrl #(.READ_LATENCY(4)) u_l4 (
    .Clk(Clk), .Rst(Rst), .Raddr(Raddr), .Waddr(Waddr), .WData(WData), .Wmask(Wmask),
    .RamRData(rd4), .RamReadReady(rdy4), .RamBusy(busy4), .AccessFault(flt4));

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          at;
    logic        rdy;
    logic [63:0] data;
    logic        flt;
  } exp_t;
  exp_t sb[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ready or fault pulse of the main instance must match the
  // oldest outstanding expectation, including the cycle it arrives in.
  always @(negedge Clk) begin
    exp_t e;
    if (rdy2 === 1'b1 || flt2 === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: ready=%b fault=%b data=%h, none expected (cycle %0d)",
                 rdy2, flt2, rd2, cyc);
      end else begin
        e = sb.pop_front();
        check64("pulse_cycle", 64'(cyc), 64'(e.at));
        check64("pulse_ready", {63'b0, rdy2}, {63'b0, e.rdy});
        check64("pulse_fault", {63'b0, flt2}, {63'b0, e.flt});
        if (e.rdy) check64("load_data", rd2, e.data);
      end
    end
  end

  task automatic cycle(input logic [63:0] ra, input logic [63:0] wa,
                       input logic [63:0] wd, input logic [3:0] wm);
    @(posedge Clk);
    #1;
    Raddr = ra;
    Waddr = wa;
    WData = wd;
    Wmask = wm;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, '0, '0);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data,
                    input logic [3:0] mask, input logic fault);
    cycle('0, addr, data, mask);
    if (fault) sb.push_back('{cyc + 1, 1'b0, 64'h0, 1'b1});
    cycle('0, '0, '0, '0);
  endtask

  task automatic rd(input logic [63:0] addr, input logic [63:0] data, input logic fault);
    cycle(addr, '0, '0, '0);
    sb.push_back('{cyc + 2, 1'b1, data, fault});
    cycle('0, '0, '0, '0);
    @(negedge Clk);
    check64("busy_t1", {63'b0, busy2}, 64'd1);
    cycle('0, '0, '0, '0);
    @(negedge Clk);
    check64("busy_t2", {63'b0, busy2}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [63:0] w0;

    idle(3);
    @(negedge Clk);
    check64("rst_rdata", rd2, 64'h0);
    check64("rst_ready", {63'b0, rdy2}, 64'd0);
    check64("rst_busy", {63'b0, busy2}, 64'd0);
    check64("rst_fault", {63'b0, flt2}, 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;

    // Basic doubleword store and load
    wr(BASE, 64'h1122_3344_5566_7788, SD, 1'b0);
    rd(BASE, 64'h1122_3344_5566_7788, 1'b0);

    // Byte store merges into the word; load is right-aligned by offset
    wr(BASE + 3, 64'hAB, SB, 1'b0);
    rd(BASE + 3, 64'h0000_0011_2233_44AB, 1'b0);
    rd(BASE, 64'h1122_3344_AB66_7788, 1'b0);

    // Misaligned SW faults and leaves the word alone; illegal code is a no-op
    wr(BASE + 2, 64'hFFFF_FFFF, SW, 1'b1);
    wr(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);
    rd(BASE, 64'h1122_3344_AB66_7788, 1'b0);

    // Halfword at offset 6
    wr(BASE + 6, 64'hBEEF, SH, 1'b0);
    rd(BASE + 6, 64'h0000_0000_0000_BEEF, 1'b0);
    w0 = 64'hBEEF_3344_AB66_7788;
    rd(BASE, w0, 1'b0);

    // Range boundaries, below, above and far above (no 32-bit wrap)
    rd(64'h7FFF_FFF8, 64'h0, 1'b1);
    wr(BASE + 64'h7FF8, 64'hCAFE_F00D_1234_5678, SD, 1'b0);
    rd(BASE + 64'h7FFC, 64'h0000_0000_CAFE_F00D, 1'b0);
    rd(BASE + 64'h8000, 64'h0, 1'b1);
    wr(BASE + 64'h8000, 64'h1, SD, 1'b1);
    rd(64'h1_8000_0000, 64'h0, 1'b1);

    // Store during WAIT is seen by the pending read; a second Raddr is ignored
    cycle(BASE + 8, '0, '0, '0);
    t = cyc;
    sb.push_back('{t + 2, 1'b1, 64'hDEAD, 1'b0});
    cycle(BASE + 16, BASE + 8, 64'hDEAD, SD);
    idle(2);

    // Read and write of the same word in the same IDLE cycle
    cycle(BASE + 24, BASE + 24, 64'h55AA, SD);
    t = cyc;
    sb.push_back('{t + 2, 1'b1, 64'h55AA, 1'b0});
    idle(2);

    // Latency 1 and 4 instances: pulse cycle, busy width and data
    idle(6);
    cycle(BASE, '0, '0, '0);
    t = cyc;
    sb.push_back('{t + 2, 1'b1, w0, 1'b0});
    for (int k = 1; k <= 6; k++) begin
      cycle('0, '0, '0, '0);
      @(negedge Clk);
      check64("l1_ready", {63'b0, rdy1}, {63'b0, (k == 1)});
      check64("l1_busy",  {63'b0, busy1}, {63'b0, (k <= 1)});
      check64("l4_ready", {63'b0, rdy4}, {63'b0, (k == 4)});
      check64("l4_busy",  {63'b0, busy4}, {63'b0, (k <= 4)});
      if (k == 1) check64("l1_data", rd1, w0);
      if (k == 4) check64("l4_data", rd4, w0);
    end

    // Reset during a pending read: no response, outputs cleared, store dropped
    wr(BASE + 16, 64'h0123_4567_89AB_CDEF, SD, 1'b0);
    idle(6);
    cycle(BASE, '0, '0, '0);
    @(posedge Clk);
    #1;
    Rst   = 1'b0;
    Raddr = '0;
    Waddr = BASE + 16;
    WData = 64'hFFFF;
    Wmask = SD;
    @(posedge Clk);
    #1;
    Rst   = 1'b1;
    Waddr = '0;
    WData = '0;
    Wmask = '0;
    @(negedge Clk);
    check64("rstmid_ready", {63'b0, rdy2}, 64'd0);
    check64("rstmid_busy", {63'b0, busy2}, 64'd0);
    check64("rstmid_fault", {63'b0, flt2}, 64'd0);
    check64("rstmid_rdata", rd2, 64'h0);
    check64("rstmid_l4_busy", {63'b0, busy4}, 64'd0);
    rd(BASE + 16, 64'h0123_4567_89AB_CDEF, 1'b0);
    rd(BASE, w0, 1'b0);

    idle(4);
    check64("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
